aes_key_sched: RTL

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_key_sched.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched.sv
// AES-128 key expansion: computes one round key per cycle into an 11-entry
// store and serves registered, validity-tagged reads of any completed entry.
`timescale 1ns/1ps

package aes_ks_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    // GF(2^8) multiply-by-x modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// Combinational AES S-box: multiplicative inverse in GF(2^8) then the affine map.
module aes_sbox
    import aes_ks_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign byte_o = affine(gf_inv(byte_i));

endmodule

// Top: FSM, round-key store and registered read port.
module aes_key_sched
    import aes_ks_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic [127:0] rk_out,
    output logic         rk_vld
);

    localparam logic [3:0] LAST_RK = 4'd10;

    state_e       state_q, state_d;
    logic [3:0]   rc_q, rc_d;
    logic [3:0]   wptr_q, wptr_d;
    logic         kv_q, kv_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic         rk_vld_q, rk_vld_d;

    logic [127:0] store_q [0:10];

    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_data;

    logic [3:0]   prev_idx;
    logic [127:0] prev_rk;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;

    // Fetch the previous round key and split it into words
    always_comb begin
        prev_idx = (rc_q == 4'd0 || rc_q > 4'd11) ? 4'd0 : rc_q - 4'd1;
        prev_rk  = store_q[prev_idx];
        w0       = prev_rk[127:96];
        w1       = prev_rk[95:64];
        w2       = prev_rk[63:32];
        w3       = prev_rk[31:0];
        rot_w    = {w3[23:0], w3[31:24]};
    end

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .byte_i (rot_w[8*g +: 8]),
            .byte_o (sub_w[8*g +: 8])
        );
    end

    // One key-expansion step from the previous round key
    always_comb begin
        t_w = sub_w ^ {rcon_q, 24'h0};
        n0  = w0 ^ t_w;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
    end

    // Next-state, store write control and read-port next values
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        rc_d    = rc_q;
        wptr_d  = wptr_q;
        kv_d    = kv_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        done_d  = done_q;
        wr_en   = 1'b0;
        wr_idx  = rc_q;
        wr_data = {n0, n1, n2, n3};

        if (kld) begin
            state_d = S_EXPAND;
            rc_d    = 4'd1;
            wptr_d  = 4'd0;
            kv_d    = 1'b1;
            rcon_d  = 8'h01;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            wr_en   = 1'b1;
            wr_idx  = 4'd0;
            wr_data = key;
        end else begin
            case (state_q)
                S_EXPAND: begin
                    wr_en  = 1'b1;
                    wptr_d = rc_q;
                    rc_d   = rc_q + 4'd1;
                    rcon_d = xtime(rcon_q);
                    if (rc_q == LAST_RK) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Only entries up to wptr are complete; the one being written now is not.
        rk_vld_d = kv_q && (rk_idx <= wptr_q);
        rk_out_d = rk_vld_d ? store_q[rk_idx] : 128'h0;
    end

    // Control and read-port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rc_q     <= 4'd0;
            wptr_q   <= 4'd0;
            kv_q     <= 1'b0;
            rcon_q   <= 8'h01;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rk_out_q <= 128'h0;
            rk_vld_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            rc_q     <= rc_d;
            wptr_q   <= wptr_d;
            kv_q     <= kv_d;
            rcon_q   <= rcon_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rk_out_q <= rk_out_d;
            rk_vld_q <= rk_vld_d;
        end
    end

    // Round-key store
    // NOTE: the store has no reset; kv/wptr gate every read, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (wr_en) store_q[wr_idx] <= wr_data;
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rk_out = rk_out_q;
    assign rk_vld = rk_vld_q;

endmodule
